// File: rtl/comar_mask_prng.sv
// Fresh-mask source for the COMAR two-share gadgets: a 32-bit Fibonacci LFSR
// stepped six times per enabled cycle, exposing its six low bits as r[5:0].
module comar_mask_prng #(
   parameter int unsigned WARMUP = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seed_valid,
   input  logic [31:0] seed,
   output logic        seed_ready,
   input  logic        enable,
   output logic [5:0]  r,
   output logic        r_valid
);

   localparam int unsigned CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;

   typedef enum logic [1:0] {
      ST_UNSEEDED = 2'd0,
      ST_WARMUP   = 2'd1,
      ST_RUN      = 2'd2
   } fsm_e;

   localparam fsm_e ST_AFTER_SEED = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic [31:0] lfsr_adv6(input logic [31:0] s);
      logic [31:0] t;
      t = s;
      for (int i = 0; i < 6; i++) begin
         t = lfsr_step(t);
      end
      return t;
   endfunction

   // An all-zero state would lock the LFSR, so a zero seed is remapped.
   function automatic logic [31:0] seed_fix(input logic [31:0] s);
      return (s == 32'h0) ? 32'h0000_0001 : s;
   endfunction

   fsm_e              fsm_q, fsm_d;
   logic [31:0]       lfsr_q, lfsr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [5:0]        r_q, r_d;
   logic              r_valid_q, r_valid_d;
   logic [31:0]       lfsr_nxt;
   logic              seed_acc;

   assign seed_ready = rst_n;
   assign seed_acc   = seed_valid & seed_ready;
   assign lfsr_nxt   = lfsr_adv6(lfsr_q);

   always_comb begin
      fsm_d     = fsm_q;
      lfsr_d    = lfsr_q;
      cnt_d     = cnt_q;
      r_d       = r_q;
      r_valid_d = 1'b0;

      if (seed_acc) begin
         lfsr_d = seed_fix(seed);
         cnt_d  = '0;
         fsm_d  = ST_AFTER_SEED;
      end else begin
         unique case (fsm_q)
            ST_UNSEEDED: begin
               fsm_d = ST_UNSEEDED;
            end
            ST_WARMUP: begin
               lfsr_d = lfsr_nxt;
               if (cnt_q == CNT_LAST) begin
                  fsm_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               // A held word is never re-flagged: mask reuse would break masking.
               if (enable) begin
                  lfsr_d    = lfsr_nxt;
                  r_d       = lfsr_nxt[5:0];
                  r_valid_d = 1'b1;
               end
            end
            default: begin
               fsm_d = ST_UNSEEDED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= ST_UNSEEDED;
         lfsr_q    <= 32'h0;
         cnt_q     <= '0;
         r_q       <= 6'h00;
         r_valid_q <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         lfsr_q    <= lfsr_d;
         cnt_q     <= cnt_d;
         r_q       <= r_d;
         r_valid_q <= r_valid_d;
      end
   end

   assign r       = r_q;
   assign r_valid = r_valid_q;

endmodule
